// File: rtl/dma_controller.sv
// Bus-master DMA engine: moves 4-word blocks from the device read port to memory.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle between blocks (default: burst).
module dma_controller #(
  parameter int WORD_SIZE  = 16,
  parameter int MAX_BLOCKS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [WORD_SIZE-1:0]   cmd_addr,
  input  logic [1:0]             cmd_blocks,
  output logic                   cmd_ready,
  output logic                   BR,
  input  logic                   BG,
  output logic [1:0]             offset,
  input  logic [4*WORD_SIZE-1:0] dev_data,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  output logic                   mem_we,
  input  logic                   mem_ack,
  output logic                   dma_done
);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, WRITE, DONE, STEAL} state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_BLOCKS);

  state_t                 state_reg, state_next;
  logic [WORD_SIZE-1:0]   base_reg, base_next;
  logic [1:0]             count_reg, count_next;
  logic [1:0]             idx_reg, idx_next;
  logic [4*WORD_SIZE-1:0] buf_reg, buf_next;
  logic [1:0]             cmd_count;
  logic [1:0]             idx_inc;
  logic                   in_write;

  assign cmd_count = (cmd_blocks > MAX_CNT) ? MAX_CNT : cmd_blocks;
  assign idx_inc   = idx_reg + 2'd1;
  assign in_write  = (state_reg == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      buf_reg   <= buf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    buf_next   = buf_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          base_next  = cmd_addr;
          count_next = cmd_count;
          idx_next   = '0;
          state_next = (cmd_count == 2'd0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (BG) state_next = FETCH;
      end
      FETCH: begin
        buf_next   = dev_data;
        state_next = WRITE;
      end
      WRITE: begin
        // The grant is only re-examined once the current block has been accepted.
        if (mem_ack) begin
          idx_next = idx_inc;
          if (idx_inc == count_reg) begin
            state_next = DONE;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            state_next = STEAL;
`else
            state_next = BG ? FETCH : REQ;
`endif
          end
        end
      end
      DONE:    state_next = IDLE;
      STEAL:   state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == IDLE);
    BR        = (state_reg == REQ) || (state_reg == FETCH) || (state_reg == WRITE);
    offset    = (state_reg == FETCH) ? idx_reg : 2'b11;
    mem_we    = in_write;
    mem_addr  = in_write ? (base_reg + (WORD_SIZE'(idx_reg) << 2)) : '0;
    dma_done  = (state_reg == DONE);
  end

  // Write data lanes are zeroed outside WRITE so the bus idles at its reset value.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign mem_wdata[gi*WORD_SIZE +: WORD_SIZE] =
      in_write ? buf_reg[gi*WORD_SIZE +: WORD_SIZE] : '0;
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller; a second instance with MAX_BLOCKS=2 checks count clamping.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, BG, mem_ack;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_blocks;

  logic        cmd_ready, BR, mem_we, dma_done;
  logic [1:0]  offset;
  logic [63:0] dev_data, mem_wdata;
  logic [15:0] mem_addr;

  logic        cmd_ready2, BR2, mem_we2, dma_done2;
  logic [1:0]  offset2;
  logic [63:0] dev_data2, mem_wdata2;
  logic [15:0] mem_addr2;

  logic [63:0] storage [4] = '{64'h0001_0002_0003_0004, 64'h1111_2222_3333_4444,
                               64'hA5A5_5A5A_C3C3_3C3C, 64'hDEAD_BEEF_DEAD_BEEF};

  int n_chk = 0, n_fail = 0;
  int n_wr = 0, n_wr2 = 0, n_base = 0, n_done = 0;
  int snap, snap2;

  assign dev_data  = storage[offset];
  assign dev_data2 = storage[offset2];

  always #5 clk = ~clk;

  dma_controller #(.WORD_SIZE(16), .MAX_BLOCKS(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_blocks(cmd_blocks), .cmd_ready(cmd_ready), .BR(BR), .BG(BG),
    .offset(offset), .dev_data(dev_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack), .dma_done(dma_done)
  );

  dma_controller #(.WORD_SIZE(16), .MAX_BLOCKS(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_blocks(cmd_blocks), .cmd_ready(cmd_ready2), .BR(BR2), .BG(BG),
    .offset(offset2), .dev_data(dev_data2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_ack(mem_ack), .dma_done(dma_done2)
  );

  // Handshake monitor, sampled mid-cycle when everything is settled.
  always @(negedge clk) begin
    if (mem_we && mem_ack) begin
      n_wr++;
      if (mem_addr == 16'h0200) n_base++;
    end
    if (mem_we2 && mem_ack) n_wr2++;
    if (dma_done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_br"}, BR, 1'b0);
    check({tag, "_offset"}, offset, 2'b11);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_addr"}, mem_addr, 16'h0000);
    check({tag, "_wdata"}, mem_wdata, 64'h0);
    check({tag, "_done"}, dma_done, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic cmd(input logic [15:0] a, input logic [1:0] b);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_blocks = b;
    step();
    cmd_valid  = 1'b0;
  endtask

  // Entered in the FETCH cycle of block i; returns in the cycle after the ack.
  task automatic blk(input logic [1:0] i, input logic [15:0] a, input logic [63:0] d,
                     input int stall, input bit last, input logic bg_w, input bit inj);
    check("fetch_offset", offset, i);
    check("fetch_br", BR, 1'b1);
    step();
    BG = bg_w;
    for (int s = 0; s <= stall; s++) begin
      check("write_we", mem_we, 1'b1);
      check("write_addr", mem_addr, a);
      check("write_data", mem_wdata, d);
      if (inj && s == 1) begin
        cmd_valid  = 1'b1;
        cmd_addr   = 16'h0BAD;
        cmd_blocks = 2'd2;
      end
      if (inj && s == 2) cmd_valid = 1'b0;
      if (s == stall) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
`ifdef DMA_CYCLE_STEAL_EN
    if (!last) begin
      check("steal_br_low", BR, 1'b0);
      step();
      if (BG) step();
    end
`endif
  endtask

  task automatic done_seq(input string tag);
    check({tag, "_done_pulse"}, dma_done, 1'b1);
    check({tag, "_done_br"}, BR, 1'b0);
    step();
    check({tag, "_done_clear"}, dma_done, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_blocks = '0;
    BG = 1'b0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    check_reset_vals("rst");

    // Burst: grant arrives two cycles after BR, one-cycle ack latency.
    snap = n_wr;
    cmd(16'h0100, 2'd3);
    check("burst_br_req", BR, 1'b1);
    check("burst_busy", cmd_ready, 1'b0);
    step();
    check("burst_br_wait", BR, 1'b1);
    BG = 1'b1;
    step();
    blk(2'd0, 16'h0100, storage[0], 1, 1'b0, 1'b1, 1'b0);
    blk(2'd1, 16'h0104, storage[1], 1, 1'b0, 1'b1, 1'b0);
    blk(2'd2, 16'h0108, storage[2], 1, 1'b1, 1'b1, 1'b0);
    done_seq("burst");
    check("burst_writes", n_wr - snap, 3);

    // Zero count goes straight to DONE.
    BG = 1'b0;
    snap = n_wr;
    cmd(16'h0123, 2'd0);
    check("zero_done", dma_done, 1'b1);
    check("zero_br", BR, 1'b0);
    check("zero_we", mem_we, 1'b0);
    step();
    check("zero_done_clear", dma_done, 1'b0);
    check("zero_ready", cmd_ready, 1'b1);
    check("zero_writes", n_wr - snap, 0);

    // Address wrap; the MAX_BLOCKS=2 instance must clamp to two writes.
    BG = 1'b1;
    snap = n_wr; snap2 = n_wr2;
    cmd(16'hFFFC, 2'd3);
    step();
    blk(2'd0, 16'hFFFC, storage[0], 0, 1'b0, 1'b1, 1'b0);
    blk(2'd1, 16'h0000, storage[1], 0, 1'b0, 1'b1, 1'b0);
    blk(2'd2, 16'h0004, storage[2], 0, 1'b1, 1'b1, 1'b0);
    done_seq("wrap");
    check("wrap_writes", n_wr - snap, 3);
    check("clamp_writes", n_wr2 - snap2, 2);

    // Grant revoked during the write of block 0.
    snap = n_wr; n_base = 0;
    cmd(16'h0200, 2'd2);
    step();
    blk(2'd0, 16'h0200, storage[0], 1, 1'b0, 1'b0, 1'b0);
    check("revoke_req_br", BR, 1'b1);
    check("revoke_req_offset", offset, 2'b11);
    check("revoke_req_we", mem_we, 1'b0);
    step();
    check("revoke_hold_br", BR, 1'b1);
    BG = 1'b1;
    step();
    blk(2'd1, 16'h0204, storage[1], 0, 1'b1, 1'b1, 1'b0);
    done_seq("revoke");
    check("revoke_writes", n_wr - snap, 2);
    check("revoke_base_once", n_base, 1);

    // Memory stall with an ignored command in the window.
    snap = n_wr;
    cmd(16'h0300, 2'd1);
    step();
    blk(2'd0, 16'h0300, storage[0], 5, 1'b1, 1'b1, 1'b1);
    done_seq("stall");
    step();
    check("stall_no_requeue_br", BR, 1'b0);
    check("stall_no_requeue_ready", cmd_ready, 1'b1);
    check("stall_writes", n_wr - snap, 1);

    // Reset during block 1 FETCH.
    cmd(16'h0400, 2'd3);
    step();
    blk(2'd0, 16'h0400, storage[0], 0, 1'b0, 1'b1, 1'b0);
    check("rstmid_fetch_offset", offset, 2'd1);
    snap = n_done;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("rstmid");
    step(); step();
    check("rstmid_no_done", n_done - snap, 0);
    cmd(16'h0500, 2'd1);
    step();
    blk(2'd0, 16'h0500, storage[0], 1, 1'b1, 1'b1, 1'b0);
    done_seq("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-master DMA engine that sits between the external device and main memory. On a CPU command it requests the bus, reads 64-bit blocks (four 16-bit words) from the device one offset at a time, and writes each block to consecutive memory addresses. It signals completion to the CPU with a one-cycle done pulse. It is the consumer side of the device's offset/data read port and of the CPU's BR/BG arbitration.

## Interface
- `WORD_SIZE`, 16, memory word width in bits; a block is 4*WORD_SIZE.
- `MAX_BLOCKS`, 3, number of device storage entries; offsets 0..MAX_BLOCKS-1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  CPU command strobe; accepted only when `cmd_ready`=1.
- `cmd_addr`  in  WORD_SIZE  destination base word address.
- `cmd_blocks`  in  2  number of 4-word blocks to move.
- `cmd_ready`  out  1  high in IDLE only.
- `BR`  out  1  bus request to CPU.
- `BG`  in  1  bus grant from CPU.
- `offset`  out  2  device read offset; 2'b11 when not fetching.
- `dev_data`  in  4*WORD_SIZE  device data for the current `offset`; valid in the same cycle.
- `mem_addr`  out  WORD_SIZE  block write address.
- `mem_wdata`  out  4*WORD_SIZE  block write data.
- `mem_we`  out  1  block write request; held until acknowledged.
- `mem_ack`  in  1  memory accepted the block (one-cycle pulse).
- `dma_done`  out  1  one-cycle completion pulse to CPU.

## Operation
- States: IDLE, REQ, FETCH, WRITE, DONE.
- IDLE: `cmd_ready`=1. `cmd_valid`=1 latches `cmd_addr` into base and the clamped count: counts above MAX_BLOCKS become MAX_BLOCKS. The block index i is cleared. If count=0, go to DONE, otherwise go to REQ.
- REQ: `BR`=1. Stay until `BG`=1 is sampled, then go to FETCH.
- FETCH: drive `offset`=i for one cycle and latch `dev_data` into the write buffer at the end of the cycle. Go to WRITE.
- WRITE: `mem_we`=1, `mem_addr`=base+4*i, `mem_wdata`=buffer. Hold all three stable until `mem_ack`=1 is sampled. Then increment i:
  - i==count → DONE.
  - `BG` low → REQ.
  - otherwise → FETCH.
- DONE: `dma_done`=1 and `BR`=0 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^WORD_SIZE, so base 16'hFFFE with block 1 writes address 16'h0002.
- BG withdrawn mid-transfer: the block in FETCH or WRITE completes its write. The engine then returns to REQ and resumes at the next i. No block is skipped or repeated.
- `cmd_valid` outside IDLE is ignored. No command is queued.
- `mem_ack` outside WRITE is ignored.
- Reset in any state returns to IDLE and abandons any partial transfer. No `dma_done` is issued.

## Timing
- Reset values: `BR`=0, `offset`=2'b11, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `dma_done`=0, `cmd_ready`=1.
- Command accepted at edge 0. `BR` is high in cycle 1.
- After `BG` is sampled high at edge n: FETCH occupies cycle n+1, and `mem_we` rises in cycle n+2.
- `mem_ack` sampled at edge m: the next FETCH (same-grant case) is in cycle m+1, and the next `mem_we` in cycle m+2.
- Minimum per block is 2 cycles, given a zero-wait `mem_ack`.
- After the last ack at edge m: cycle m+1 is DONE (`BR`=0, `dma_done`=1), and `cmd_ready`=1 from cycle m+2.
- In burst mode `BR` stays high from REQ through the last WRITE.

## Configuration
- `DMA_CYCLE_STEAL_EN` defined (cycle stealing): after each acknowledged block that is not the last, drop `BR` for one cycle and re-enter REQ. The CPU regains the bus between blocks.
- Not defined (burst): `BR` is held continuously for the whole transfer, and REQ is re-entered only if `BG` drops.

## Test plan
- Burst transfer: base 16'h0100, 3 blocks, BG granted 2 cycles after BR, ack one cycle after each `mem_we`. Expect:
  - writes to 16'h0100, 16'h0104 and 16'h0108 carrying device storage[0..2];
  - one `dma_done` pulse, then `BR`=0.
- Zero count: `cmd_blocks`=0. Expect `dma_done` in cycle 1, `BR` never asserted and `mem_we` never asserted.
- Clamp and wrap: `cmd_blocks`=3 with base 16'hFFFC. Expect three writes, to 16'hFFFC, 16'h0000 and 16'h0004. Repeat with MAX_BLOCKS=2: expect only two writes.
- Grant revoked: drop BG during the WRITE of block 0. Expect:
  - block 0 completes;
  - the engine re-enters REQ with `BR`=1;
  - after the re-grant, block 1 goes to base+4 and there is no duplicate write to base.
- Memory stall: hold `mem_ack` low for 5 cycles. Expect `mem_we`, `mem_addr` and `mem_wdata` stable for all 5 cycles. A `cmd_valid` pulse in that window is ignored.
- Reset mid-transfer: assert `reset` during block 1 FETCH. Expect every output at its reset value on the next cycle, no `dma_done`, and a new command accepted normally. With `DMA_CYCLE_STEAL_EN`, also check a one-cycle `BR` low between blocks.
